ospi_host_master: RTL

//  Single-lane 8-bit OSPI host that sits directly upstream of the OSPI device controller.
//  - Accepts a transaction request (read/write, 32-bit address, byte length) from a bus-side client.
//  - Drives cs_n, sclk and the command/address phases onto dq.
//  - For writes, streams write bytes out on dq; for reads, releases dq and samples the returned bytes.
//  - Fixed device protocol, one byte per clk, no dummy cycles:
//    cs_n low, 1 setup cycle, CMD (1 byte), ADDR (4 bytes, MSB first), DATA.

---
 rtl/ospi_host_master.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ospi_host_master.sv
// ospi_host_master: single-lane 8-bit OSPI host issuing CMD + 4-byte ADDR + DATA bursts.
//   clk, rst_n                        clock; asynchronous active-low reset
//   req_valid/ready/write/addr/len    transaction request, accepted only in IDLE
//   wdata, wdata_valid, wdata_ready   write byte stream; ready marks the load edge
//   rdata, rdata_valid                read bytes, one-cycle pulse each, no backpressure
//   done, err                         end-of-transaction pulse; err = write underrun abort
//   tx_count                          successful-transaction counter (OSPI_HOST_STATS_EN)
//   cs_n, sclk, dq                    device pins; dq tri-stated when not driven
// Optional feature macro: OSPI_HOST_STATS_EN builds the tx_count counter, else tx_count is 0.
module ospi_host_master #(
  parameter int LEN_W = 8,
  parameter logic [7:0] CMD_WRITE = 8'h02,
  parameter logic [7:0] CMD_READ = 8'h03
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             err,
  output logic [15:0]      tx_count,
  output logic             cs_n,
  output logic             sclk,
  inout  wire  [7:0]       dq
);
  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DATA, END} state_t;
  state_t state, state_next;
  logic [LEN_W-1:0] cnt, cnt_next, len_q;
  logic [LEN_W:0] cnt_x;
  logic [31:0] addr_q;
  logic [7:0] dq_o;
  logic write_q, oe, addr_end, fin, abt, smp, last, cs_n_d;
  assign dq = oe ? dq_o : 'z;
  assign req_ready = state == IDLE;
  // cnt counts address bytes in ADDR, then bytes loaded (write) or sampled (read) in DATA
  assign addr_end = state == ADDR && cnt == LEN_W'(4);
  assign wdata_ready = write_q && len_q != '0 && (addr_end || state == DATA);
  assign abt = wdata_ready && !wdata_valid;
  assign smp = !write_q && (state == DATA || state == END);
  assign fin = state == END || (addr_end && len_q == '0);
  // END is the cycle before the terminating edge: last byte on dq (write) or last byte due (read)
  assign cnt_x = {1'b0, cnt} + (LEN_W+1)'(write_q ? 1 : 2);
  assign last = cnt_x == {1'b0, len_q};
  assign cs_n_d = state == IDLE ? !req_valid : (fin || abt);
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    case (state)
      IDLE:  state_next = req_valid ? SETUP : IDLE;
      SETUP: state_next = CMD;
      CMD: begin
        state_next = ADDR;
        cnt_next = LEN_W'(1);
      end
      ADDR: begin
        state_next = !addr_end ? ADDR : (fin || abt) ? IDLE : len_q == LEN_W'(1) ? END : DATA;
        cnt_next = !addr_end ? cnt + LEN_W'(1) : LEN_W'(write_q);
      end
      DATA: begin
        state_next = abt ? IDLE : last ? END : DATA;
        cnt_next = cnt + LEN_W'(1);
      end
      END:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      dq_o <= '0;
      oe <= 1'b0;
      cs_n <= 1'b1;
      sclk <= 1'b0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      cs_n <= cs_n_d;
      sclk <= !cs_n_d && !sclk;
      rdata_valid <= smp;
      done <= fin || abt;
      err <= abt;
      if (state == IDLE && req_valid) begin
        write_q <= req_write;
        addr_q <= req_addr;
        len_q <= req_len;
      end
      if (state == SETUP) begin
        dq_o <= write_q ? CMD_WRITE : CMD_READ;
        oe <= 1'b1;
      end
      if (state == CMD || (state == ADDR && !addr_end)) begin
        dq_o <= addr_q[31:24];
        addr_q <= {addr_q[23:0], 8'h00};
      end
      if (wdata_ready && wdata_valid) dq_o <= wdata;
      if (smp) rdata <= dq;
      // release dq for the device's read data and at every transaction end
      if ((addr_end && !write_q) || fin || abt) oe <= 1'b0;
    end
  end
`ifdef OSPI_HOST_STATS_EN
  logic [15:0] tx_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_cnt <= '0;
    else if (fin) tx_cnt <= tx_cnt + 16'd1;
  end
  assign tx_count = tx_cnt;
`else
  assign tx_count = '0;
`endif
endmodule
